right_shift_seq: RTL
====================

Name: right_shift_seq

Overview:
- Multi-cycle right shifter for the ALU shift path; the right-direction counterpart to the combinational left shifter.
- Supports logical (SRL) and arithmetic (SRA) right shift of a 32-bit operand by a 5-bit amount.
- Evaluates one binary shift stage per clock: 16, 8, 4, 2, then 1. Fixed 5-cycle latency.
- A start/busy/done handshake lets the MCU control unit stall while the shift completes.

Parameters:
- DATA_W, 32, operand/result width. Must be a power of two, ≥ 2.
- SHAMT_W, 5, shift-amount width. Must equal log2(DATA_W).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse. Sampled only when busy=0.
- A  input  DATA_W  operand to shift. Sampled with start.
- shamt  input  SHAMT_W  shift amount. Sampled with start.
- arith  input  1  fill select. 1 = SRA (fill with A[DATA_W-1]); 0 = SRL (zero fill). Sampled with start.
- busy  output  1  high while a shift is in progress.
- done  output  1  single-cycle pulse: result is valid.
- result  output  DATA_W  shifted value. Held stable from done until the next accepted start completes.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, result=0, internal operand/amount/stage registers cleared. Reset aborts any in-progress shift; no done is issued for the aborted request.
- States:
  - IDLE: busy=0. When start=1: latch A into the working register, and latch shamt, arith, and the fill bit (arith & A[DATA_W-1]). Set stage index k=SHAMT_W-1. Go to SHIFT.
  - SHIFT: busy=1. Each cycle, if shamt_lat[k]=1, shift the working register right by 2^k, filling vacated MSBs with the latched fill bit; otherwise hold.
    - If k≠0: decrement k, stay in SHIFT.
    - If k=0: write the final value to result, pulse done=1 for the next cycle, go to IDLE.
- Latency: start sampled at edge N; done=1 and result valid during the cycle after edge N+5 (SHAMT_W shift edges). Throughput: one shift per SHAMT_W+1 cycles.
- start while busy=1: ignored; no queuing.
- start in the same cycle done=1: accepted (busy is already 0), giving back-to-back operation. result still holds the previous value until the new done.
- A, shamt and arith may change freely after they are sampled; only latched copies are used.
- shamt=0: the full 5 cycles still elapse; result=A.
- shamt=DATA_W-1 with SRA on a negative operand: result is all ones. With SRL: result=1 if A[DATA_W-1]=1.
- result is registered. It never changes except at the done-producing edge or at reset.

Optional Feature:
- Macro RIGHT_SHIFT_ROTATE_EN adds input port rot (1 bit, sampled with start).
- With macro defined and rot=1: each active stage rotates right (vacated MSBs take the bits shifted out of the LSBs), and arith is ignored. rot=0 behaves as SRL/SRA. Latency is unchanged.
- Without macro: no rot port exists, and only SRL/SRA are provided.

Decomposition:
- Shared package alu_shift_pkg:
  - DATA_W and SHAMT_W constants.
  - State enum {IDLE, SHIFT}.
  - Shift-mode encoding constants SH_SRL=2'b00, SH_SRA=2'b01, SH_ROR=2'b10, also reused by the ALU op decoder.
- One sub-module: shift_stage_r. Purely combinational single-stage right shifter with inputs data, amount-as-stage-index, fill bit, and rotate flag. It is instantiated once and driven by k each cycle, not replicated per stage.

Test Plan:
- Reset, then start with A=0x8000_0000, shamt=4, arith=0 → busy high for 5 cycles; done pulse one cycle; result=0x0800_0000.
- A=0x8000_0000, shamt=4, arith=1 → result=0xF800_0000. Same operand with shamt=31, arith=1 → 0xFFFF_FFFF; with arith=0 → 0x0000_0001.
- A=0x1234_5678, shamt=0 → after exactly 5 shift cycles, result=0x1234_5678.
- Drive start=1 on every cycle, with A changed each cycle, during a shift of A=0xFFFF_0000, shamt=8, SRL → extra starts ignored; result=0x00FF_FF00. A start coincident with done is accepted, and the second result follows 6 cycles later.
- Assert rst on the 3rd SHIFT cycle → next cycle busy=0, done=0, result=0; no done pulse follows.
- With RIGHT_SHIFT_ROTATE_EN: A=0x0000_00F1, shamt=4, rot=1 → result=0x1000_000F.

Source files
------------

// File: rtl/alu_shift_pkg.sv
// Shared ALU shift-path definitions: widths, sequencer states and shift-mode codes.
// Mode codes are also decoded by the ALU op decoder, so keep values stable.
package alu_shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = $clog2(DATA_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SRA = 2'b01;
  localparam logic [1:0] SH_ROR = 2'b10;

  // Width of a stage index able to count SHAMT_W-1 down to 0.
  function automatic int stage_idx_w(input int shamt_w);
    return (shamt_w > 1) ? $clog2(shamt_w) : 1;
  endfunction

endpackage

// File: rtl/right_shift_seq_stage.sv
// One right-shift stage: shifts data by 2^k, filling from the fill bit or rotating.
// Purely combinational, zero latency; no flow control of its own.
// Reused every cycle by the sequencer with a changing k rather than replicated.
module shift_stage_r #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int K_W     = 3
) (
  input  logic [DATA_W-1:0] data,
  input  logic [K_W-1:0]    k,
  input  logic              fill,
  input  logic              rot,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] hi;

  // The upper half supplies the vacated MSBs: the operand itself for a rotate.
  assign hi = rot ? data : {DATA_W{fill}};
  assign y  = DATA_W'({hi, data} >> (1 << k));

endmodule

// File: rtl/right_shift_seq.sv
// Sequential SRL/SRA (plus ROR when RIGHT_SHIFT_ROTATE_EN is defined), one 2^k stage per clock.
// Latency SHAMT_W+1 cycles start-to-done; result held until the next done.
// start is ignored while busy; a start during the done cycle is accepted back-to-back.
module right_shift_seq #(
  parameter int DATA_W  = alu_shift_pkg::DATA_W,
  parameter int SHAMT_W = alu_shift_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  A,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
`ifdef RIGHT_SHIFT_ROTATE_EN
  input  logic               rot,
`endif
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  import alu_shift_pkg::*;

  localparam int K_W = stage_idx_w(SHAMT_W);
  localparam logic [K_W-1:0] K_TOP = K_W'(SHAMT_W - 1);

  state_t             state;
  logic [DATA_W-1:0]  work;
  logic [SHAMT_W-1:0] shamt_lat;
  logic [1:0]         mode_lat;
  logic               sign_lat;
  logic [K_W-1:0]     k;

  logic               stage_fill;
  logic               stage_rot;
  logic [DATA_W-1:0]  stage_y;
  logic [DATA_W-1:0]  next_work;
  logic [1:0]         mode_in;

  // Rotate takes priority over arith, so arith is a don't-care for ROR.
`ifdef RIGHT_SHIFT_ROTATE_EN
  assign mode_in = rot ? SH_ROR : (arith ? SH_SRA : SH_SRL);
`else
  assign mode_in = arith ? SH_SRA : SH_SRL;
`endif

  assign stage_fill = (mode_lat == SH_SRA) && sign_lat;
  assign stage_rot  = (mode_lat == SH_ROR);

  shift_stage_r #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W),
    .K_W     (K_W)
  ) u_stage (
    .data (work),
    .k    (k),
    .fill (stage_fill),
    .rot  (stage_rot),
    .y    (stage_y)
  );

  assign next_work = shamt_lat[k] ? stage_y : work;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      work      <= '0;
      shamt_lat <= '0;
      mode_lat  <= SH_SRL;
      sign_lat  <= 1'b0;
      k         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work      <= A;
            shamt_lat <= shamt;
            mode_lat  <= mode_in;
            sign_lat  <= A[DATA_W-1];
            k         <= K_TOP;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          work <= next_work;
          if (k != '0) begin
            k <= k - K_W'(1);
          end else begin
            result <= next_work;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
